uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions
//
// Purpose: state encoding and frame constants used by both uart_rx and uart_tx.
// Ports:   none (package).
package uart_pkg;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      STOP    = 3'd4,
      CLEANUP = 3'd5
   } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - input synchroniser for the asynchronous serial line
//
// Purpose: SYNC_STAGES-deep flop chain bringing i_rx_serial into the i_clock
//          domain. Flops reset to the idle line level so reset never looks
//          like a start bit.
// Ports:
//   clk_i  in   system clock
//   rst_i  in   synchronous, active-high reset
//   d_i    in   asynchronous input
//   q_o    out  synchronised output, SYNC_STAGES cycles behind d_i
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);
   import uart_pkg::*;

   if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("uart_rx_sync: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN)
//
// Purpose: synchronises the serial line, qualifies the start bit at its
//          centre, samples 8 data bits LSB first (plus an even-parity bit
//          when UART_RX_PARITY_EN is defined) and checks the stop bit.
// Build option: define UART_RX_PARITY_EN to add the PARITY state.
// Ports:
//   i_clock      in   system clock
//   i_rst        in   synchronous, active-high reset
//   i_rx_serial  in   asynchronous serial line, idle high
//   o_rx_dv      out  one-cycle pulse, o_rx_byte valid
//   o_rx_byte    out  last good byte, held between frames
//   o_rx_active  out  high while a frame is being received
//   o_frame_err  out  one-cycle pulse, bad stop (or parity) bit
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       i_clock,
   input  logic       i_rst,
   input  logic       i_rx_serial,
   output logic       o_rx_dv,
   output logic [7:0] o_rx_byte,
   output logic       o_rx_active,
   output logic       o_frame_err
);
   import uart_pkg::*;

   if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 255) begin : g_bad_cpb
      $error("uart_rx: CLKS_PER_BIT must be in 4..255");
   end

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

   logic                 rx_s;
   logic                 stop_ok;
   uart_state_e          state_q;
   logic [CW-1:0]        cnt_q;
   logic [2:0]           idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [7:0]           byte_q;
   logic                 rx_dv_q;
   logic                 frame_err_q;
   logic                 active_q;

   uart_rx_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (i_clock),
      .rst_i (i_rst),
      .d_i   (i_rx_serial),
      .q_o   (rx_s)
   );

`ifdef UART_RX_PARITY_EN
   logic par_bad_q;

   // A good stop bit is not enough if the parity bit disagreed.
   assign stop_ok = rx_s & ~par_bad_q;
`else
   assign stop_ok = rx_s;
`endif

   always_ff @(posedge i_clock) begin
      if (i_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         byte_q      <= '0;
         rx_dv_q     <= 1'b0;
         frame_err_q <= 1'b0;
         active_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q   <= 1'b0;
`endif
      end else begin
         rx_dv_q     <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q    <= '0;
               idx_q    <= '0;
               active_q <= 1'b0;
               if (!rx_s) begin
                  state_q <= START;
               end
            end
            START: begin
               // Re-check the line half a bit in; a high level here was a glitch.
               if (cnt_q == HALF_LAST) begin
                  cnt_q <= '0;
                  if (!rx_s) begin
                     state_q  <= DATA;
                     active_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q          <= '0;
                  shift_q[idx_q] <= rx_s;
                  if (idx_q == IDX_LAST) begin
                     idx_q   <= '0;
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q     <= '0;
                  // Even parity: the parity bit equals the XOR of the data bits.
                  par_bad_q <= rx_s ^ (^shift_q);
                  state_q   <= STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`endif
            STOP: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q    <= '0;
                  active_q <= 1'b0;
                  state_q  <= CLEANUP;
                  if (stop_ok) begin
                     byte_q  <= shift_q;
                     rx_dv_q <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            CLEANUP: begin
               // After a break the line may stay low; do not rearm until it idles.
               active_q <= 1'b0;
               if (rx_s) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q  <= IDLE;
               cnt_q    <= '0;
               idx_q    <= '0;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_rx_dv     = rx_dv_q;
   assign o_rx_byte   = byte_q;
   assign o_rx_active = active_q;
   assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

   localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
   localparam int EXTRA = CPB;
`else
   localparam int EXTRA = 0;
`endif
   localparam int LAT_NOM = 2 + CPB / 2 + 9 * CPB + EXTRA;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       rx = 1'b1;
   logic       o_rx_dv;
   logic [7:0] o_rx_byte;
   logic       o_rx_active;
   logic       o_frame_err;

   always #5 clk = ~clk;

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (2)
   ) dut (
      .i_clock     (clk),
      .i_rst       (i_rst),
      .i_rx_serial (rx),
      .o_rx_dv     (o_rx_dv),
      .o_rx_byte   (o_rx_byte),
      .o_rx_active (o_rx_active),
      .o_frame_err (o_frame_err)
   );

   typedef struct {
      logic [7:0] data;
      logic       stop_bit;
      int         exp_dv;
      int         exp_err;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs [6];

   int total = 0;
   int bad   = 0;
   int cyc, n_dv, n_err, n_act, n_both;
   int         dv_at [$];
   logic [7:0] got   [$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic clr();
      cyc = 0; n_dv = 0; n_err = 0; n_act = 0; n_both = 0;
      dv_at.delete();
      got.delete();
   endtask

   // One clock: wait for the falling edge, then observe the outputs.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (o_rx_dv) begin
         n_dv++;
         dv_at.push_back(cyc);
         got.push_back(o_rx_byte);
      end
      if (o_frame_err) n_err++;
      if (o_rx_active) n_act++;
      if (o_rx_dv && o_frame_err) n_both++;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      repeat (CPB) tick();
   endtask

   task automatic send_frame_p(input logic [7:0] d, input logic par_flip, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ par_flip);
`else
      if (par_flip) rx = rx;
`endif
      send_bit(stop);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_frame_p(d, 1'b0, stop);
   endtask

   initial begin
      int a0;

      vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
      vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
      vecs[3] = '{8'h81, 1'b0, 0, 1, 8'hFF};
      vecs[4] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
      vecs[5] = '{8'hC3, 1'b0, 0, 1, 8'h3C};

      // Reset with the line idle.
      rx    = 1'b1;
      i_rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dv", int'(o_rx_dv), 0);
      chk("rst_err", int'(o_frame_err), 0);
      chk("rst_active", int'(o_rx_active), 0);
      chk("rst_byte", int'(o_rx_byte), 0);
      i_rst = 1'b0;
      clr();
      repeat (100) tick();
      chk("idle_active", n_act, 0);
      chk("idle_dv", n_dv + n_err, 0);

      // Table-driven single frames, each followed by an idle gap.
      for (int v = 0; v < 6; v++) begin
         clr();
         send_frame(vecs[v].data, vecs[v].stop_bit);
         rx = 1'b1;
         repeat (20) tick();
         chk($sformatf("v%0d_dv", v), n_dv, vecs[v].exp_dv);
         chk($sformatf("v%0d_err", v), n_err, vecs[v].exp_err);
         chk($sformatf("v%0d_byte", v), int'(o_rx_byte), int'(vecs[v].exp_byte));
         chk($sformatf("v%0d_both", v), n_both, 0);
         chk_rng($sformatf("v%0d_active", v), n_act, 9 * CPB + EXTRA - 4, 10 * CPB + EXTRA);
         if (vecs[v].exp_dv == 1 && dv_at.size() > 0)
            chk_rng($sformatf("v%0d_latency", v), dv_at[0], LAT_NOM - 1, LAT_NOM + 1);
      end

      // Glitch shorter than half a bit, then a real frame.
      clr();
      rx = 1'b0;
      repeat (3) tick();
      rx = 1'b1;
      repeat (30) tick();
      chk("glitch_active", n_act, 0);
      chk("glitch_out", n_dv + n_err, 0);
      clr();
      send_frame(8'h3C, 1'b1);
      rx = 1'b1;
      repeat (20) tick();
      chk("post_glitch_dv", n_dv, 1);
      chk("post_glitch_byte", int'(o_rx_byte), 8'h3C);

      // Back-to-back frames with no idle gap.
      clr();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      rx = 1'b1;
      repeat (20) tick();
      chk("b2b_dv", n_dv, 2);
      chk("b2b_err", n_err, 0);
      if (got.size() == 2) begin
         chk("b2b_byte0", int'(got[0]), 8'h00);
         chk("b2b_byte1", int'(got[1]), 8'hFF);
         chk("b2b_spacing", dv_at[1] - dv_at[0], 10 * CPB + EXTRA);
      end

      // Framing error followed by a break: must wait for the line to idle.
      clr();
      send_frame(8'h3C, 1'b0);
      a0 = n_act;
      repeat (20) tick();
      chk("break_active", n_act - a0, 0);
      rx = 1'b1;
      repeat (20) tick();
      chk("ferr_err", n_err, 1);
      chk("ferr_dv", n_dv, 0);
      chk("ferr_byte_held", int'(o_rx_byte), 8'hFF);
      clr();
      send_frame(8'h5A, 1'b1);
      rx = 1'b1;
      repeat (20) tick();
      chk("post_ferr_dv", n_dv, 1);
      chk("post_ferr_byte", int'(o_rx_byte), 8'h5A);

      // Reset during data bit 4.
      clr();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'(8'hA5 >> i));
      rx = 1'b0;
      repeat (4) tick();
      i_rst = 1'b1;
      rx    = 1'b1;
      repeat (3) tick();
      chk("mid_rst_active", int'(o_rx_active), 0);
      chk("mid_rst_byte", int'(o_rx_byte), 0);
      i_rst = 1'b0;
      repeat (100) tick();
      chk("mid_rst_dv", n_dv, 0);
      chk("mid_rst_err", n_err, 0);
      chk("mid_rst_byte_after", int'(o_rx_byte), 0);

`ifdef UART_RX_PARITY_EN
      clr();
      send_frame_p(8'h5A, 1'b0, 1'b1);
      rx = 1'b1;
      repeat (20) tick();
      chk("par_ok_dv", n_dv, 1);
      chk("par_ok_err", n_err, 0);
      chk("par_ok_byte", int'(o_rx_byte), 8'h5A);
      clr();
      send_frame_p(8'h33, 1'b1, 1'b1);
      rx = 1'b1;
      repeat (20) tick();
      chk("par_bad_dv", n_dv, 0);
      chk("par_bad_err", n_err, 1);
      chk("par_bad_byte", int'(o_rx_byte), 8'h5A);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
